// File: rtl/telemetry_tx.sv
// telemetry_tx: periodic/triggered UART telemetry framer (header, channel count, channel words, XOR checksum).
module telemetry_tx #(
    parameter int NUM_CH   = 3,
    parameter int DW       = 12,
    parameter int BAUD_DIV = 434,
    parameter int PERIOD   = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 trig,
    input  logic [NUM_CH*DW-1:0] ch_data,
    output logic                 TX,
    output logic                 busy,
    output logic                 frm_done
);
    localparam int NB = 2*NUM_CH+3;
    localparam int IW = $clog2(NB);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_CH*DW-1:0] snap_q, snap_d;
    logic                 pend_q, pend_d, done_q, done_d;
    logic                 req, tick, wrap;
    logic [7:0]           frame [NB];
    logic [7:0]           csum, cur;
    logic [15:0]          w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            snap_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign wrap    = timer_q == TW'(PERIOD-1);
    assign req     = (en && wrap) || trig;
    assign timer_d = (!en || wrap) ? '0 : timer_q + 1'b1;
    assign tick    = baud_q == BW'(BAUD_DIV-1);

    // Whole frame is derived from the snapshot, so the byte index alone selects the outgoing byte.
    always_comb begin
        w        = '0;
        csum     = 8'(NUM_CH);
        frame[0] = 8'hA5;
        frame[1] = 8'(NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            w            = 16'(snap_q[i*DW +: DW]);
            frame[2*i+2] = w[15:8];
            frame[2*i+3] = w[7:0];
            csum         = csum ^ w[15:8] ^ w[7:0];
        end
        frame[NB-1] = csum;
    end

    assign cur      = frame[idx_q];
    assign TX       = state_q == START ? 1'b0 : state_q == DATA ? cur[bit_q] : 1'b1;
    assign busy     = state_q != IDLE;
    assign frm_done = done_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE: if (req || pend_q) begin
                state_d = START;
                snap_d  = ch_data;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (tick) begin
                bit_d   = bit_q + 1'b1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            default: if (tick) begin
                if (idx_q == IW'(NB-1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = START;
                end
            end
        endcase
        if (state_q != IDLE && req)
            pend_d = 1'b1;
    end
endmodule

// File: doc/telemetry_tx.md
TELEMETRY_TX -- requirements
Module: telemetry_tx

Interface
REQ-001 Parameter NUM_CH, default 3, number of sampled channels per frame (1..15).
REQ-002 Parameter DW, default 12, channel data width in bits (1..16).
REQ-003 Parameter BAUD_DIV, default 434, clk cycles per UART bit (>=2).
REQ-004 Parameter PERIOD, default 1048576, clk cycles between periodic frame starts (>=2).
REQ-005 Port list, one per line (name, direction, width, meaning), clock and reset first:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  enables periodic frames.
- trig  input  1  single-cycle request for an immediate frame.
- ch_data  input  NUM_CH*DW  channel i occupies bits [i*DW +: DW].
- TX  output  1  UART serial out, 8N1, LSB first, idle high.
- busy  output  1  high while a frame is being transmitted.
- frm_done  output  1  one-cycle pulse after the final stop bit of a frame.

Function
REQ-006 Frame = 2*NUM_CH+3 bytes, in order: header 0xA5; NUM_CH as a byte; per channel 0..NUM_CH-1, high byte then low byte of the value zero-extended to 16 bits; checksum.
REQ-007 Checksum = XOR of every byte after the header, up to and including the last channel low byte.
REQ-008 All channels are snapshotted into an internal register in the cycle a frame start is accepted; ch_data changes mid-frame do not alter the frame.
REQ-009 Period timer counts 0..PERIOD-1 and wraps; it runs only while en=1 and clears to 0 while en=0.
REQ-010 Frame request = (timer==PERIOD-1 and en) or trig.
REQ-011 Request while idle: frame start accepted that cycle; busy rises the next cycle; the TX start bit begins the same cycle as busy.
REQ-012 Request while busy: sets a single pending flag; further requests while pending is set are dropped (no queue beyond depth 1).
REQ-013 Pending set at frame end: the next frame starts in the cycle after frm_done, with a fresh snapshot; pending is cleared on that start.
REQ-014 Simultaneous periodic and trig requests in one cycle count as a single request.
REQ-015 Byte FSM states IDLE, START, DATA, STOP; each bit is held exactly BAUD_DIV cycles; DATA shifts 8 bits LSB first; STOP drives 1.
REQ-016 Frame sequencer advances the byte index 0..2*NUM_CH+2 after each STOP; back-to-back bytes have no idle gap.
REQ-017 frm_done pulses in the cycle after the last STOP bit completes; busy falls in that same cycle.
REQ-018 The bit counter, byte index and baud counter are sized to their parameter maxima and never overflow.

Reset
REQ-019 While rst=1: TX=1, busy=0, frm_done=0; FSM in IDLE; timer, pending flag, byte index and baud counter cleared.
REQ-020 rst asserted mid-frame aborts the frame: TX=1 from the cycle after the reset edge; no frm_done is produced; the aborted frame is not resumed.
REQ-021 After rst deasserts, the first periodic request occurs PERIOD cycles later if en=1 throughout.

Verification (NUM_CH=3, DW=12, BAUD_DIV=4, PERIOD=1000 unless stated)
REQ-022 ch_data = {0x7FF,0xABC,0x123}, trig pulse -> TX bytes A5 03 01 23 0A BC 07 FF 6F; each bit 4 cycles; busy for 9*10*4=360 cycles; one frm_done.
REQ-023 trig during a frame, then a second trig during the same frame -> exactly one further frame, starting the cycle after frm_done; its contents reflect ch_data at that start.
REQ-024 en=1 held, no trig -> frame starts every 1000 cycles; en dropped for 1 cycle -> the timer restarts from 0.
REQ-025 rst pulsed at bit 37 of a frame -> TX=1 the next cycle; busy=0; no frm_done; a subsequent trig yields a complete, correct frame.
REQ-026 NUM_CH=1, DW=16, ch_data=0xFFFF -> bytes A5 01 FF FF 01.
REQ-027 ch_data changed every cycle during a frame -> transmitted bytes match the value sampled at frame start.
